// File: rtl/cache_way_ram.sv
// rtl/cache_way_ram.sv - multi-way set RAM with byte-enabled writes, write-first reads and self-clearing init
//
// Optional build macro: CACHE_WAY_RAM_OUTREG_EN adds one output register stage (read latency 2).
//
// Ports:
//   clk        in   sole clock, rising edge
//   resetn     in   asynchronous active-low reset
//   clr_req    in   pulse, zero all ways (honoured only when ready)
//   init_busy  out  high while the clear sequence runs
//   wr_en      in   write strobe
//   wr_way     in   target way (values >= NUM_WAYS write nothing)
//   wr_strb    in   byte enables, bit i covers wr_data[8i+7:8i]
//   wr_addr    in   write set index
//   wr_data    in   write data
//   rd_en      in   read strobe, reads every way of one set
//   rd_addr    in   read set index
//   rd_data    out  way w at bits [w*LEN_DATA +: LEN_DATA]
//   rd_valid   out  rd_data holds a completed read
`timescale 1ns/1ps
module cache_way_ram #(
    parameter int LEN_DATA = 32,
    parameter int LEN_ADDR = 10,
    parameter int NUM_WAYS = 2,
    localparam int LEN_WAY = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         clr_req,
    output logic                         init_busy,
    input  logic                         wr_en,
    input  logic [LEN_WAY-1:0]           wr_way,
    input  logic [LEN_DATA/8-1:0]        wr_strb,
    input  logic [LEN_ADDR-1:0]          wr_addr,
    input  logic [LEN_DATA-1:0]          wr_data,
    input  logic                         rd_en,
    input  logic [LEN_ADDR-1:0]          rd_addr,
    output logic [NUM_WAYS*LEN_DATA-1:0] rd_data,
    output logic                         rd_valid
);

    localparam int DEPTH     = 2 ** LEN_ADDR;
    localparam int NUM_BYTES = LEN_DATA / 8;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                        state_q, state_d;
    logic [LEN_ADDR-1:0]           cnt_q, cnt_d;
    logic                          rd_valid_q;
    logic [NUM_WAYS*LEN_DATA-1:0]  rd_data_q, rd_data_d;
    logic [LEN_DATA-1:0]           rd_word;
    logic                          ready;
    logic                          rd_accept;
    logic                          wr_accept;

    // No reset on the array: its contents are defined only by the INIT sweep.
    logic [LEN_DATA-1:0] mem_q [NUM_WAYS][DEPTH];

    assign ready     = (state_q == ST_READY);
    assign rd_accept = ready && rd_en;
    assign wr_accept = ready && wr_en;
    assign init_busy = (state_q == ST_INIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                // Counter wraps back to 0 on the last index, ready for the next clear.
                cnt_d = cnt_q + LEN_ADDR'(1);
                if (cnt_q == {LEN_ADDR{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!ready) begin
                mem_q[w][cnt_q] <= '0;
            end else if (wr_en && (wr_way == LEN_WAY'(w))) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (wr_strb[b]) begin
                        mem_q[w][wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Write-first bypass: a same-cycle write to the read set is merged byte by byte.
    always_comb begin
        rd_data_d = '0;
        rd_word   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            rd_word = mem_q[w][rd_addr];
            if (wr_accept && (wr_addr == rd_addr) && (wr_way == LEN_WAY'(w))) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (wr_strb[b]) begin
                        rd_word[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
            rd_data_d[w*LEN_DATA +: LEN_DATA] = rd_word;
        end
    end

`ifdef CACHE_WAY_RAM_OUTREG_EN
    logic                         rd_valid_p_q;
    logic [NUM_WAYS*LEN_DATA-1:0] rd_data_p_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid_p_q <= 1'b0;
            rd_data_p_q  <= '0;
        end else begin
            rd_valid_p_q <= rd_valid_q;
            if (rd_valid_q) begin
                rd_data_p_q <= rd_data_q;
            end
        end
    end

    assign rd_valid = rd_valid_p_q;
    assign rd_data  = rd_data_p_q;
`else
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_cache_way_ram.sv
// tb/tb_cache_way_ram.sv - scoreboard bench for cache_way_ram with a behavioural memory model
`timescale 1ns/1ps
module tb_cache_way_ram;

`ifdef CACHE_WAY_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        resetn;
    logic        clr_req;
    logic        init_busy;
    logic        wr_en;
    logic [0:0]  wr_way;
    logic [3:0]  wr_strb;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        rd_valid;

    cache_way_ram #(.LEN_DATA(32), .LEN_ADDR(10), .NUM_WAYS(2)) dut (
        .clk(clk), .resetn(resetn), .clr_req(clr_req), .init_busy(init_busy),
        .wr_en(wr_en), .wr_way(wr_way), .wr_strb(wr_strb), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [2][1024];
    bit          ready;
    int          edges;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic zero_model();
        for (int w = 0; w < 2; w++)
            for (int a = 0; a < 1024; a++)
                model[w][a] = 32'h0;
    endtask

    task automatic idle();
        clr_req = 0; wr_en = 0; wr_way = 0; wr_strb = 0; wr_addr = 0;
        wr_data = 0; rd_en = 0; rd_addr = 0;
    endtask

    // One request cycle; the model applies writes before reads (write-first).
    task automatic step(input bit wr, input int way, input logic [3:0] strb, input int waddr,
                        input logic [31:0] wdata, input bit rd, input int raddr, input bit clr);
        exp_t e;
        wr_en = wr; wr_way = 1'(way); wr_strb = strb; wr_addr = 10'(waddr); wr_data = wdata;
        rd_en = rd; rd_addr = 10'(raddr); clr_req = clr;
        if (ready) begin
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[way][waddr][8*b +: 8] = wdata[8*b +: 8];
            if (rd) begin
                e.data = {model[1][raddr], model[0][raddr]};
                e.due  = edges + LAT;
                sb.push_back(e);
            end
            if (clr) begin
                ready = 0;
                zero_model();
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    // Counts busy cycles; optionally hammers the ignored inputs meanwhile.
    task automatic wait_init(input bit noise);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 3000) begin
            if (noise) begin
                rd_en = 1; rd_addr = 10'($urandom); clr_req = 1;
                wr_en = 1; wr_way = 1'($urandom); wr_strb = 4'hF; wr_addr = 10'h020;
                wr_data = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            n++;
        end
        idle();
        chk("init_len", 64'(n), 64'd1024);
        ready = 1;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    chk("rd_valid_spurious", 64'(rd_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_data", rd_data, e.data);
                    chk("rd_latency", 64'(edges), 64'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= edges) begin
                chk("rd_valid_missing", 64'(rd_valid), 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; ready = 0;
        zero_model();
        idle();
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(init_busy), 64'd1);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        resetn = 1;
        wait_init(0);

        // Fresh clear: top index reads zero
        step(0, 0, 0, 0, 0, 1, 10'h3FF, 0);
        // Partial-strobe write, then read
        step(1, 1, 4'b0101, 10'h005, 32'hAABBCCDD, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 10'h005, 0);
        // Same-cycle write/read to one set
        step(1, 0, 4'hF, 10'h010, 32'h12345678, 1, 10'h010, 0);
        // Read immediately after write
        step(1, 1, 4'b1000, 10'h011, 32'h9900_0000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 10'h011, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 15),
                 $urandom, $urandom_range(0, 1), $urandom_range(0, 15), 0);
        end

        // Clear with ignored traffic during INIT, read+clear combined
        step(1, 0, 4'hF, 10'h020, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 10'h020, 1);
        wait_init(1);
        step(0, 0, 0, 0, 0, 1, 10'h020, 0);

        // Reset at counter 500 of INIT
        step(1, 1, 4'hF, 10'h030, 32'h0BAD_F00D, 0, 0, 1);
        repeat (500) @(posedge clk);
        #1;
        resetn = 0;
        #1;
        chk("midinit_busy", 64'(init_busy), 64'd1);
        chk("midinit_rd_valid", 64'(rd_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        wait_init(0);
        step(0, 0, 0, 0, 0, 1, 10'h030, 0);

        // Reset while a read result is presented
        step(1, 0, 4'hF, 10'h040, 32'hCAFE_0001, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 10'h040, 0);
        repeat (LAT - 1) begin @(posedge clk); #1; end
        chk("midread_valid_before", 64'(rd_valid), 64'd1);
        void'(sb.pop_front());
        #1;
        resetn = 0;
        #1;
        chk("midread_rd_valid", 64'(rd_valid), 64'd0);
        chk("midread_rd_data", rd_data, 64'd0);
        chk("midread_busy", 64'(init_busy), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        ready = 0;
        zero_model();
        resetn = 1;
        wait_init(0);
        step(0, 0, 0, 0, 0, 1, 10'h040, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_way_ram.md
CACHE_WAY_RAM -- requirements
Module: cache_way_ram

Interface
REQ-001 SHALL have parameter LEN_DATA, default 32, width of one way's word in bits (multiple of 8).
REQ-002 SHALL have parameter LEN_ADDR, default 10, set-index width; DEPTH = 2**LEN_ADDR.
REQ-003 SHALL have parameter NUM_WAYS, default 2, number of independent ways; LEN_WAY = max(1, clog2(NUM_WAYS)).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 clr_req  in  1  pulse; requests zeroing of all ways.
REQ-008 init_busy  out  1  high while the clear sequence runs.
REQ-009 wr_en  in  1  write strobe.
REQ-010 wr_way  in  LEN_WAY  target way of the write.
REQ-011 wr_strb  in  LEN_DATA/8  byte enables; bit i covers data[8i+7:8i].
REQ-012 wr_addr  in  LEN_ADDR  write set index.
REQ-013 wr_data  in  LEN_DATA  write data.
REQ-014 rd_en  in  1  read strobe; reads all ways of one set.
REQ-015 rd_addr  in  LEN_ADDR  read set index.
REQ-016 rd_data  out  NUM_WAYS*LEN_DATA  way w at bits [w*LEN_DATA +: LEN_DATA].
REQ-017 rd_valid  out  1  rd_data holds a completed read.

Function
REQ-018 FSM states SHALL be INIT and READY; reset enters INIT with clear counter = 0.
REQ-019 INIT SHALL write zero to all ways at counter index each cycle, increment the counter, and move to READY after index DEPTH-1; duration exactly DEPTH cycles.
REQ-020 init_busy SHALL be 1 exactly while state = INIT.
REQ-021 In INIT, wr_en, rd_en and clr_req SHALL be ignored; rd_valid held 0.
REQ-022 In READY, clr_req = 1 SHALL move to INIT with counter = 0 on the next edge.
REQ-023 In READY, wr_en SHALL update only bytes of way wr_way at wr_addr whose wr_strb bit is 1; wr_way >= NUM_WAYS SHALL write nothing.
REQ-024 In READY, rd_en in cycle t SHALL present all ways of rd_addr on rd_data with rd_valid = 1 in cycle t+1 (latency 1).
REQ-025 rd_valid SHALL be 0 in any cycle not following an accepted read; rd_data SHALL hold its last value when no read completes.
REQ-026 Same-cycle wr_en and rd_en to the same address SHALL return write-first data: strobed bytes of wr_way from wr_data, all other bytes and ways from stored contents.
REQ-027 A read in the cycle after a write to the same address SHALL return the written data.
REQ-028 clr_req together with rd_en/wr_en in READY SHALL first service the read/write, then clear; the read completes normally.

Reset
REQ-029 resetn low SHALL asynchronously force state = INIT, counter = 0, init_busy = 1, rd_valid = 0, rd_data = 0.
REQ-030 resetn low mid-INIT or mid-read SHALL abort the operation; the clear restarts from index 0 after release.
REQ-031 Memory array contents SHALL NOT depend on reset; only the INIT sequence defines them.

Configuration
REQ-032 With macro CACHE_WAY_RAM_OUTREG_EN defined, one extra output register stage SHALL be added: read latency 2 cycles, rd_valid delayed in step, pipeline stage reset to 0.
REQ-033 Without CACHE_WAY_RAM_OUTREG_EN, read latency SHALL be 1 cycle per REQ-024.

Verification (LEN_DATA=32, LEN_ADDR=10, NUM_WAYS=2, macro off unless stated)
REQ-034 Release resetn -> init_busy = 1 for exactly 1024 cycles, then 0; read addr 0x3FF -> rd_data = 0.
REQ-035 Write way 1, addr 0x005, strb 4'b0101, data 0xAABBCCDD over zero -> read addr 0x005 gives way1 = 0x00BB00DD, way0 = 0.
REQ-036 Same-cycle write way 0 addr 0x010 data 0x12345678 strb 4'hF with read addr 0x010 -> next cycle rd_valid = 1, way0 = 0x12345678.
REQ-037 Data at 0x020 nonzero; pulse clr_req -> init_busy = 1 for 1024 cycles, rd_en ignored meanwhile; after, read 0x020 = 0.
REQ-038 Assert resetn low at counter 500 of INIT -> rd_valid = 0 immediately; after release init_busy lasts 1024 full cycles.
REQ-039 Macro CACHE_WAY_RAM_OUTREG_EN defined: read in cycle t -> rd_valid = 1 and data in cycle t+2, not t+1.
